cr_fifo_rd_prefetch: RTL and testbench
======================================

Name: cr_fifo_rd_prefetch

Overview:
- Read-side stage that sits directly downstream of the ECC-protected 1R1W RAM FIFO wrapper.
- Issues FIFO read enables whenever the FIFO is non-empty and local credit exists, and absorbs the RAM read latency.
- Holds returned words in a small skid buffer and presents them on a valid/ready stream, so consumers get full-throughput, stall-tolerant data without seeing the FIFO's read timing.
- Also carries per-word ECC error status and a transfer counter.

Parameters:
- DATA_WIDTH, 83: width of FIFO rdata and of out_data.
- RD_LATENCY, 1: cycles from fifo_ren high to fifo_rdata valid. Legal values are 1 and 2.
- BUF_DEPTH, RD_LATENCY+2: skid buffer entries. This is the minimum depth for one word per cycle with a stalled-credit-free issue rule.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  FIFO empty flag. Updated at the edge after a ren, so it already reflects that read.
- fifo_ren  out  1  FIFO read enable.
- fifo_rdata  in  DATA_WIDTH  FIFO read data, valid RD_LATENCY cycles after fifo_ren.
- fifo_ecc_err  in  1  uncorrectable ECC error, qualified with fifo_rdata.
- hold  in  1  when high, no new fifo_ren is issued. In-flight reads still complete.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_WIDTH  head-of-buffer word.
- out_ecc_err  out  1  ECC error flag stored with the head word.
- buf_count  out  clog2(BUF_DEPTH+1)  occupied buffer entries.
- xfer_cnt  out  16  count of accepted output words. Wraps at 2^16.

Behaviour:
- Reset (async assert, sync deassert is upstream's job):
  - fifo_ren=0, out_valid=0, out_data=0, out_ecc_err=0, buf_count=0, xfer_cnt=0.
  - Inflight pipe cleared; read and write pointers = 0.
  - Any read in flight at reset is discarded. The FIFO is reset by the same rst_n.
- Issue rule, combinational from registered state:
  - fifo_ren = !fifo_empty && !hold && (buf_count + inflight < BUF_DEPTH).
  - inflight = number of set bits in a RD_LATENCY-deep valid shift register fed by fifo_ren.
  - Pops in the same cycle are not credited. This keeps the path short.
- Return:
  - When the shift register's last stage is 1, fifo_rdata and fifo_ecc_err are written at wr_ptr at the end of that cycle.
  - wr_ptr then increments modulo BUF_DEPTH.
- Output:
  - out_valid = (buf_count != 0).
  - out_data and out_ecc_err are read at rd_ptr. This is a registered-storage mux with no bypass.
  - A pop happens when out_valid && out_ready; rd_ptr increments modulo BUF_DEPTH and xfer_cnt increments.
- Latency:
  - fifo_ren in cycle c → data captured end of c+RD_LATENCY → out_valid in cycle c+RD_LATENCY+1.
  - Empty-to-first-out_valid = RD_LATENCY+1 cycles after fifo_empty falls (with hold=0).
- Throughput: with out_ready tied high and the FIFO non-empty, one word per cycle in steady state.
- buf_count next value = buf_count + return − pop.
  - A return and a pop in the same cycle leave it unchanged.
  - A return into a full buffer cannot occur by construction. An assertion flags it.
- Stall: out_ready=0 holds out_data/out_ecc_err stable while out_valid=1. The buffer fills to BUF_DEPTH and fifo_ren stops.
- hold rising mid-stream: issue stops next cycle. Up to RD_LATENCY returns still land and are delivered.
- fifo_empty rising: no new issues. Returns already in flight still land.
- Pointer wrap: pointers are clog2(BUF_DEPTH) bits with explicit compare-to-(BUF_DEPTH-1) wrap, since BUF_DEPTH is not a power of 2.
- xfer_cnt wraps 16'hFFFF→0 silently.
- out_ecc_err only marks data. The block never drops or stalls on errors.

Decomposition:
- Shared package cr_fifo_pkg:
  - RD_LATENCY_MAX=2 constant.
  - Typedef for the buffer entry struct {ecc_err, data}.
  - Function clog2 used for pointer and count widths.
- One sub-module: cr_fifo_rd_skidbuf.
  - A BUF_DEPTH-entry circular buffer with push/pop, count and head outputs.
  - The top holds the issue logic, inflight pipe and xfer_cnt.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 words in flight → all outputs 0 the same cycle. After release with FIFO empty, fifo_ren stays 0 and no stale word appears.
- Streaming: RD_LATENCY=1, FIFO preloaded with 10 words 0..9, out_ready=1 → first out_valid 2 cycles after fifo_empty falls. Words 0..9 arrive on 10 consecutive cycles and xfer_cnt=10.
- Backpressure: out_ready=0 for 8 cycles with 10 words available → buf_count saturates at 3 and fifo_ren drops. out_data holds word 0. On release, all 10 words arrive in order with none lost or duplicated.
- Last word: FIFO holds exactly 1 word → exactly one fifo_ren pulse, one out_valid word, then out_valid=0.
- hold and latency 2: RD_LATENCY=2, hold raised after 3 issues → exactly 3 words delivered. Issue resumes the cycle after hold falls.
- ECC and wrap: fifo_ecc_err=1 on word 4 → out_ecc_err=1 only with word 4. Preset xfer_cnt to 16'hFFFE and pop 3 words → xfer_cnt=1.

Source files
------------

// File: rtl/cr_fifo_pkg.sv
// Shared definitions for the FIFO read-side prefetch stage.
//   RD_LATENCY_MAX : largest supported RAM read latency
//   CR_DATA_WIDTH  : payload width carried in a buffer entry
//   cr_entry_t     : one skid-buffer entry {ecc_err, data}
//   cr_clog2()     : ceiling log2 for pointer and count widths
package cr_fifo_pkg;

    localparam int RD_LATENCY_MAX = 2;
    localparam int CR_DATA_WIDTH  = 83;

    typedef struct packed {
        logic                     ecc_err;
        logic [CR_DATA_WIDTH-1:0] data;
    } cr_entry_t;

    // Bounded loop keeps this usable as a constant function at elaboration.
    function automatic int cr_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cr_fifo_rd_skidbuf.sv
// Circular buffer of DEPTH entries that holds words returned from the RAM FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_entry at the write pointer this cycle
// push_entry   : entry to store
//   pop        : retire the head entry (ignored when empty)
//   head       : entry at the read pointer, straight from storage (no bypass)
//   count      : occupied entries
//   full       : count == DEPTH
module cr_fifo_rd_skidbuf
    import cr_fifo_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int PTR_W = cr_clog2(DEPTH),
    parameter int CNT_W = cr_clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  cr_entry_t        push_entry,
    input  logic             pop,
    output cr_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    cr_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    // DEPTH is generally not a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop && (count != '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    // The issue rule reserves a slot for every read in flight, so a return
    // can never meet a full buffer.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full));

endmodule

// File: rtl/cr_fifo_rd_prefetch.sv
// Read-side prefetch stage behind the ECC-protected RAM FIFO. Issues reads
// while the FIFO is non-empty and buffer credit remains, absorbs the RAM read
// latency and presents returned words on a valid/ready stream.
//   fifo_empty / fifo_ren / fifo_rdata / fifo_ecc_err : FIFO read port
//   hold        : blocks new reads; reads already issued still land
//   out_valid / out_ready / out_data / out_ecc_err    : output stream
//   buf_count   : occupied skid-buffer entries
//   xfer_cnt    : accepted output words, wraps at 2^16
// Handshake: a word transfers in every cycle where out_valid && out_ready;
// out_data/out_ecc_err stay stable while out_valid is high and out_ready low.
// DATA_WIDTH may not exceed CR_DATA_WIDTH (the stored entry width).
module cr_fifo_rd_prefetch
    import cr_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = CR_DATA_WIDTH,
    parameter  int RD_LATENCY = 1,
    parameter  int BUF_DEPTH  = RD_LATENCY + 2,
    localparam int CNT_W      = cr_clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_ecc_err,
    input  logic                  hold,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_ecc_err,
    output logic [CNT_W-1:0]      buf_count,
    output logic [15:0]           xfer_cnt
);

    logic [RD_LATENCY-1:0] inflight_sr;
    logic [CNT_W-1:0]      inflight;
    logic                  ret;
    logic                  pop;
    logic [15:0]           xfer_q;
    cr_entry_t             ret_entry;
    cr_entry_t             head;
    logic                  buf_full;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(inflight_sr[i]);
        end
    end

    // Credit counts only registered state; a pop in the same cycle is not
    // credited, which keeps fifo_ren off the out_ready path.
    assign fifo_ren = !fifo_empty && !hold &&
                      (({1'b0, buf_count} + {1'b0, inflight}) < (CNT_W + 1)'(BUF_DEPTH));

    assign ret = inflight_sr[RD_LATENCY-1];
    assign pop = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_sr <= '0;
            xfer_q      <= '0;
        end else begin
            inflight_sr[0] <= fifo_ren;
            for (int i = 1; i < RD_LATENCY; i++) begin
                inflight_sr[i] <= inflight_sr[i-1];
            end
            if (pop) begin
                xfer_q <= xfer_q + 16'd1;
            end
        end
    end

    assign ret_entry.ecc_err = fifo_ecc_err;
    assign ret_entry.data    = CR_DATA_WIDTH'(fifo_rdata);

    cr_fifo_rd_skidbuf #(
        .DEPTH (BUF_DEPTH)
    ) u_skidbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (ret),
        .push_entry (ret_entry),
        .pop        (pop),
        .head       (head),
        .count      (buf_count),
        .full       (buf_full)
    );

    assign out_valid   = (buf_count != '0);
    assign out_data    = DATA_WIDTH'(head.data);
    assign out_ecc_err = head.ecc_err;
    assign xfer_cnt    = xfer_q;

    a_latency_legal: assert property (@(posedge clk)
        (RD_LATENCY >= 1) && (RD_LATENCY <= RD_LATENCY_MAX));

    a_full_means_no_credit: assert property (@(posedge clk) disable iff (!rst_n)
        buf_full |-> !fifo_ren);

endmodule

// File: tb/tb_cr_fifo_rd_prefetch.sv
// Bench for cr_fifo_rd_prefetch: two lanes (RD_LATENCY 1 and 2), each with a
// FIFO environment model, a queue-level reference model and a per-cycle compare.
module tb_cr_fifo_rd_prefetch;
    import cr_fifo_pkg::*;

    localparam int W = 83;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit lane_done [2];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    endtask

    function automatic logic [W:0] rnd_bits();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[W:0];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int L  = g + 1;
        localparam int D  = L + 2;
        localparam int CW = cr_clog2(D + 1);

        logic          rst_n, fifo_empty, fifo_ren, fifo_ecc_err, hold;
        logic          out_valid, out_ready, out_ecc_err;
        logic [W-1:0]  fifo_rdata, out_data;
        logic [CW-1:0] buf_count;
        logic [15:0]   xfer_cnt;

        cr_fifo_rd_prefetch #(.DATA_WIDTH(W), .RD_LATENCY(L)) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .fifo_empty   (fifo_empty),
            .fifo_ren     (fifo_ren),
            .fifo_rdata   (fifo_rdata),
            .fifo_ecc_err (fifo_ecc_err),
            .hold         (hold),
            .out_valid    (out_valid),
            .out_ready    (out_ready),
            .out_data     (out_data),
            .out_ecc_err  (out_ecc_err),
            .buf_count    (buf_count),
            .xfer_cnt     (xfer_cnt)
        );

        // Environment: the RAM FIFO as seen by the DUT.
        logic [W:0] fq [$];
        logic [W:0] rpipe [2];
        logic       ren_s;

        // Reference model: FIFO contents, pending returns, expected buffer.
        logic [W:0] mq [$];
        logic [W:0] pend_w [$];
        int         pend_due [$];
        logic [W:0] exp_q [$];
        logic [15:0] m_xfer;
        logic       exp_ren;
        int         cyc = 0;

        initial begin
            forever begin
                @(posedge clk);
                #1;
                if (rst_n) begin
                    for (int i = L - 1; i > 0; i--) rpipe[i] = rpipe[i-1];
                    if (ren_s && fq.size() != 0) rpipe[0] = fq.pop_front();
                    else rpipe[0] = rnd_bits();
                    {fifo_ecc_err, fifo_rdata} = rpipe[L-1];
                    fifo_empty = (fq.size() == 0);
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                exp_ren = (mq.size() != 0) && !hold && (exp_q.size() + pend_w.size() < D);
                check($sformatf("lane%0d fifo_ren", g), fifo_ren, exp_ren);
                check($sformatf("lane%0d out_valid", g), out_valid, exp_q.size() != 0);
                check($sformatf("lane%0d buf_count", g), buf_count, exp_q.size());
                check($sformatf("lane%0d xfer_cnt", g), xfer_cnt, m_xfer);
                if (exp_q.size() != 0) begin
                    check($sformatf("lane%0d out_data", g), out_data, exp_q[0][W-1:0]);
                    check($sformatf("lane%0d out_ecc_err", g), out_ecc_err, exp_q[0][W]);
                end
                ren_s = fifo_ren;
                // advance the model through the coming clock edge
                if (exp_q.size() != 0 && out_ready) begin
                    void'(exp_q.pop_front());
                    m_xfer = m_xfer + 16'd1;
                end
                if (pend_due.size() != 0 && pend_due[0] == cyc) begin
                    exp_q.push_back(pend_w.pop_front());
                    void'(pend_due.pop_front());
                end
                if (exp_ren) begin
                    pend_w.push_back(mq.pop_front());
                    pend_due.push_back(cyc + L);
                end
            end else begin
                ren_s = 1'b0;
            end
            cyc++;
        end

        task automatic step(input int n);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        endtask

        task automatic do_reset();
            rst_n = 1'b0;
            hold = 1'b0;
            out_ready = 1'b0;
            fq.delete(); mq.delete(); pend_w.delete(); pend_due.delete(); exp_q.delete();
            rpipe[0] = '0; rpipe[1] = '0;
            fifo_empty = 1'b1; fifo_rdata = '0; fifo_ecc_err = 1'b0;
            m_xfer = '0;
            ren_s = 1'b0;
        endtask

        task automatic load(input int n, input int ecc_at);
            logic [W:0] w;
            for (int i = 0; i < n; i++) begin
                w = rnd_bits();
                w[W] = (i == ecc_at);
                w[15:0] = 16'(i);
                fq.push_back(w);
                mq.push_back(w);
            end
            if (n > 0) fifo_empty = 1'b0;
        endtask

        task automatic wait_idle(input int max_cyc);
            int n;
            n = 0;
            hold = 1'b0;
            out_ready = 1'b1;
            while ((fq.size() != 0 || exp_q.size() != 0 || pend_w.size() != 0) && n < max_cyc) begin
                step(1);
                n++;
            end
            if (n >= max_cyc) begin
                chk_cnt++;
                $display("FAIL lane%0d drain: still busy after %0d cycles, want idle", g, n);
            end
            step(2);
        endtask

        task automatic reset_checks(input string tag);
            check($sformatf("lane%0d %s fifo_ren", g, tag), fifo_ren, 0);
            check($sformatf("lane%0d %s out_valid", g, tag), out_valid, 0);
            check($sformatf("lane%0d %s out_data", g, tag), out_data, 0);
            check($sformatf("lane%0d %s out_ecc_err", g, tag), out_ecc_err, 0);
            check($sformatf("lane%0d %s buf_count", g, tag), buf_count, 0);
            check($sformatf("lane%0d %s xfer_cnt", g, tag), xfer_cnt, 0);
        endtask

        task automatic random_phase(input int cycles);
            for (int i = 0; i < cycles; i++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                hold = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) == 0) load(int'($urandom_range(1, 4)), int'($urandom_range(0, 4)) - 1);
                step(1);
            end
            wait_idle(300);
        endtask

        if (g == 0) begin : seq_lat1
            initial begin
                int ren_n, val_n;
                do_reset();
                step(3);
                reset_checks("reset");
                rst_n = 1'b1;
                step(2);

                // streaming: 10 words, first out_valid two cycles after empty falls
                out_ready = 1'b1;
                load(10, -1);
                @(negedge clk); check("lane0 stream first ren", fifo_ren, 1);
                @(negedge clk); check("lane0 stream valid c+1", out_valid, 0);
                @(negedge clk); check("lane0 stream valid c+2", out_valid, 1);
                check("lane0 stream word0", out_data[15:0], 16'd0);
                wait_idle(100);
                @(negedge clk); check("lane0 stream xfer_cnt", xfer_cnt, 16'd10);

                // backpressure: buffer saturates at 3, issue stops, head held
                step(1);
                out_ready = 1'b0;
                load(10, -1);
                step(8);
                @(negedge clk);
                check("lane0 bp buf_count", buf_count, 3);
                check("lane0 bp fifo_ren", fifo_ren, 0);
                check("lane0 bp head word", out_data[15:0], 16'd0);
                wait_idle(100);
                @(negedge clk); check("lane0 bp xfer_cnt", xfer_cnt, 16'd20);

                // last word: one read, one output word
                step(1);
                out_ready = 1'b1;
                load(1, -1);
                ren_n = 0; val_n = 0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    ren_n += int'(fifo_ren);
                    val_n += int'(out_valid);
                end
                check("lane0 last ren pulses", ren_n, 1);
                check("lane0 last valid cycles", val_n, 1);

                // ECC flag travels with word 4 only
                step(1);
                load(6, 4);
                wait_idle(100);
                @(negedge clk); check("lane0 ecc xfer_cnt", xfer_cnt, 16'd27);

                // xfer_cnt wrap
                step(1);
                force dut.xfer_q = 16'hFFFE;
                m_xfer = 16'hFFFE;
                #1;
                release dut.xfer_q;
                load(3, -1);
                wait_idle(100);
                @(negedge clk); check("lane0 wrap xfer_cnt", xfer_cnt, 16'd1);

                // reset mid-stream with reads in flight
                step(1);
                out_ready = 1'b0;
                load(5, -1);
                step(2);
                do_reset();
                #1;
                reset_checks("midreset");
                step(2);
                rst_n = 1'b1;
                step(3);
                @(negedge clk);
                check("lane0 post-reset out_valid", out_valid, 0);
                check("lane0 post-reset fifo_ren", fifo_ren, 0);

                step(1);
                random_phase(400);
                lane_done[0] = 1'b1;
            end
        end else begin : seq_lat2
            initial begin
                int n, guard;
                do_reset();
                step(3);
                reset_checks("reset");
                rst_n = 1'b1;
                step(2);

                // hold after three issues
                out_ready = 1'b1;
                load(8, -1);
                n = 0; guard = 0;
                while (n < 3 && guard < 20) begin
                    @(negedge clk);
                    if (fifo_ren) n++;
                    guard++;
                end
                check("lane1 issues before hold", n, 3);
                step(1);
                hold = 1'b1;
                step(10);
                @(negedge clk);
                check("lane1 hold xfer_cnt", xfer_cnt, 16'd3);
                check("lane1 hold out_valid", out_valid, 0);
                check("lane1 hold fifo_ren", fifo_ren, 0);
                step(1);
                hold = 1'b0;
                @(negedge clk); check("lane1 resume fifo_ren", fifo_ren, 1);
                wait_idle(100);
                @(negedge clk); check("lane1 final xfer_cnt", xfer_cnt, 16'd8);

                step(1);
                random_phase(400);
                lane_done[1] = 1'b1;
            end
        end
    end

    initial begin
        fork
            wait (lane_done[0] && lane_done[1]);
            begin
                #200000;
                chk_cnt++;
                $display("FAIL watchdog: lanes done %0d %0d, want 1 1", lane_done[0], lane_done[1]);
            end
        join_any
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
